// File: rtl/dmem_pkg.sv
// dmem_param shared types and default geometry.
// Imported by the interface, the clear FSM and the top.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dmem_state_t;

  localparam int DMEM_DW = 8;
  localparam int DMEM_AW = 8;

endpackage

// File: rtl/dmem_if.sv
// Load/store side bus of the data memory.
// The core drives master, the memory implements slave.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DW = DMEM_DW,
  parameter int AW = DMEM_AW
);

  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          ready;

  modport master (
    output we, re, addr, di,
    input  dout, rvalid, ready
  );

  modport slave (
    input  we, re, addr, di,
    output dout, rvalid, ready
  );

endinterface

// File: rtl/dmem_clear_fsm.sv
// Post-reset zero-clear sweep over every entry.
// ready rises on the edge that writes the last entry.
module dmem_clear_fsm
  import dmem_pkg::*;
#(
  parameter int AW             = DMEM_AW,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);

  dmem_state_t state_q, state_d;
  logic [AW:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we_o  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we_o  = 1'b1;
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == PTR_LAST)
            state_d = ST_READY;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign clr_addr_o = clr_ptr_q[AW-1:0];
  assign ready_o    = (state_q == ST_READY);

endmodule

// File: rtl/dmem_param.sv
// Parametrised data memory with optional registered read
// and a hardware zero-clear sweep after reset.
module dmem_param
  import dmem_pkg::*;
#(
  parameter int DW             = DMEM_DW,
  parameter int AW             = DMEM_AW,
  parameter int READ_LAT       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] guts [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          ready;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] dout_q, dout_d;
  logic          rvalid_q, rvalid_d;

  dmem_clear_fsm #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk        (clk),
    .reset      (reset),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  // The sweep owns the write port until ready; user writes are dropped.
  always_comb begin
    wr_en   = clr_we;
    wr_addr = clr_addr;
    wr_data = '0;
    if (ready) begin
      wr_en   = bus.we;
      wr_addr = bus.addr;
      wr_data = bus.di;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      guts[wr_addr] <= wr_data;
  end

  // Registered read samples the array before this edge's write.
  always_comb begin
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    if (ready && bus.re) begin
      dout_d   = guts[bus.addr];
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    bus.ready = ready;
    if (READ_LAT == 0) begin
      bus.dout   = ready ? guts[bus.addr] : '0;
      bus.rvalid = ready;
    end else begin
      bus.dout   = dout_q;
      bus.rvalid = rvalid_q;
    end
  end

endmodule

// File: tb/tb_dmem_param.sv
// Directed bench for dmem_param across four parameter sets
// sharing one clock and reset.
module tb_dmem_param;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_if #(.DW(8),  .AW(4)) if0 ();
  dmem_if #(.DW(8),  .AW(4)) if1 ();
  dmem_if #(.DW(16), .AW(6)) if2 ();
  dmem_if #(.DW(8),  .AW(4)) if3 ();

  dmem_param #(.DW(8), .AW(4), .READ_LAT(0), .CLEAR_ON_RESET(1))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  dmem_param #(.DW(8), .AW(4), .READ_LAT(1), .CLEAR_ON_RESET(1))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_param #(.DW(16), .AW(6), .READ_LAT(0), .CLEAR_ON_RESET(1))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  dmem_param #(.DW(8), .AW(4), .READ_LAT(1), .CLEAR_ON_RESET(0))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic we, input logic [5:0] a,
                         input logic [15:0] d);
    if0.we = we; if0.addr = a[3:0]; if0.di = d[7:0];
    if1.we = we; if1.addr = a[3:0]; if1.di = d[7:0];
    if2.we = we; if2.addr = a;      if2.di = d;
    if3.we = we; if3.addr = a[3:0]; if3.di = d[7:0];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
    tbl[2] = '{1'b1, 4'd3,  8'h5A, 8'hA5};
    tbl[3] = '{1'b0, 4'd3,  8'h00, 8'h5A};
    tbl[4] = '{1'b1, 4'd15, 8'hFF, 8'h00};
    tbl[5] = '{1'b0, 4'd15, 8'h00, 8'hFF};
    tbl[6] = '{1'b0, 4'd0,  8'h00, 8'h00};
    tbl[7] = '{1'b0, 4'd14, 8'h00, 8'h00};

    reset = 1'b1;
    set_all(1'b0, 6'd0, 16'h0);
    if0.re = 1'b0; if1.re = 1'b0; if2.re = 1'b0; if3.re = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0",  32'(if0.ready),  0);
    chk("rst_dout0",   32'(if0.dout),   0);
    chk("rst_rvalid0", 32'(if0.rvalid), 0);
    chk("rst_rvalid1", 32'(if1.rvalid), 0);
    chk("rst_dout1",   32'(if1.dout),   0);
    chk("rst_rvalid3", 32'(if3.rvalid), 0);
    chk("rst_ready3",  32'(if3.ready),  0);

    // Partial sweep, then reset at clr_ptr == 9.
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_ready0", 32'(if0.ready), 0);
    chk("mid_ready3", 32'(if3.ready), 1);
    reset = 1'b1;
    #1;
    chk("rerst_ready3",  32'(if3.ready),  0);
    chk("rerst_rvalid3", 32'(if3.rvalid), 0);
    @(negedge clk);
    set_all(1'b1, 6'd2, 16'hFFFF);
    reset = 1'b0;

    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("edge%0d_ready0", i), 32'(if0.ready), 32'(i >= 16));
      chk($sformatf("edge%0d_ready1", i), 32'(if1.ready), 32'(i >= 16));
      chk($sformatf("edge%0d_ready3", i), 32'(if3.ready), 1);
      if (i >= 63)
        chk($sformatf("edge%0d_ready2", i), 32'(if2.ready), 32'(i == 64));
      if (i == 10)
        set_all(1'b0, 6'd0, 16'h0);
    end

    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      if0.addr = 4'(a);
      #1;
      chk($sformatf("clr0_addr%0d", a), 32'(if0.dout), 0);
    end
    chk("ready_rvalid0", 32'(if0.rvalid), 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if0.we   = tbl[i].we;
      if0.addr = tbl[i].addr;
      if0.di   = tbl[i].di;
      #1;
      chk($sformatf("tbl%0d_dout", i), 32'(if0.dout), 32'(tbl[i].exp));
    end
    @(negedge clk);
    if0.we = 1'b0;

    // Registered read, read-first on a same-address write.
    if1.we = 1'b1; if1.addr = 4'd7; if1.di = 8'h11;
    @(posedge clk);
    #1;
    chk("rl1_idle_rvalid", 32'(if1.rvalid), 0);
    chk("rl1_idle_dout",   32'(if1.dout),   0);
    @(negedge clk);
    if1.re = 1'b1; if1.di = 8'h3C;
    @(posedge clk);
    #1;
    chk("rl1_rf_dout",   32'(if1.dout),   32'h11);
    chk("rl1_rf_rvalid", 32'(if1.rvalid), 1);
    @(negedge clk);
    if1.we = 1'b0;
    @(posedge clk);
    #1;
    chk("rl1_new_dout",   32'(if1.dout),   32'h3C);
    chk("rl1_new_rvalid", 32'(if1.rvalid), 1);
    @(negedge clk);
    if1.re = 1'b0; if1.addr = 4'd0;
    @(posedge clk);
    #1;
    chk("rl1_hold_dout",   32'(if1.dout),   32'h3C);
    chk("rl1_hold_rvalid", 32'(if1.rvalid), 0);

    // Wide config: top entry, no aliasing onto entry 0.
    @(negedge clk);
    if2.we = 1'b1; if2.addr = 6'd63; if2.di = 16'hBEEF;
    #1;
    chk("w16_pre", 32'(if2.dout), 0);
    @(posedge clk);
    #1;
    if2.we = 1'b0;
    #1;
    chk("w16_top", 32'(if2.dout), 32'hBEEF);
    if2.addr = 6'd0;
    #1;
    chk("w16_zero", 32'(if2.dout), 0);
    if2.addr = 6'd2;
    #1;
    chk("w16_drop", 32'(if2.dout), 0);

    // No-clear config accepted the early writes to entry 2.
    @(negedge clk);
    if3.re = 1'b1; if3.addr = 4'd2;
    @(posedge clk);
    #1;
    chk("nc_dout",   32'(if3.dout),   32'hFF);
    chk("nc_rvalid", 32'(if3.rvalid), 1);
    @(negedge clk);
    if3.re = 1'b0;
    @(posedge clk);
    #1;
    chk("nc_rvalid_clr", 32'(if3.rvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
